data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
- Data-memory access controller sitting directly downstream of the data size selector; consumes its 2-bit DataSize together with address, data and direction from the datapath.
- Owns a byte-addressed data RAM and performs BYTE/HALF/WORD/DWORD transfers with programmable wait states.
- Signals completion to the control unit through the MFA/MOC handshake.

Parameters:
- DEPTH, 256: RAM size in bytes; power of two, at least 8.
- WAIT_CYCLES, 2: wait states per word beat; at least 1.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- MFA  input  1  memory function activate (request), level
- RW  input  1  1 = read, 0 = write
- DataSize  input  2  00 BYTE, 01 HALF, 10 WORD, 11 DWORD
- Address  input  32  byte address
- DataIn  input  32  write data; low word for DWORD
- DataInHi  input  32  DWORD second word, written at Address+4
- DataOut  output  32  read data; low word for DWORD
- DataOutHi  output  32  DWORD second word, read from Address+4
- MOC  output  1  memory operation complete, one-cycle pulse
- Busy  output  1  high in any state other than IDLE
- Misaligned  output  1  valid while MOC is high; 1 = request rejected

Behaviour:
- Reset values: DataOut=0, DataOutHi=0, MOC=0, Busy=0, Misaligned=0, state=IDLE. RAM contents are not cleared.
- Byte order is big-endian: the byte at address A is bits [31:24] of the word at A.
- Address wraps modulo DEPTH: only Address[log2(DEPTH)-1:0] is used, and Address+4 wraps the same way.
- FSM states: IDLE, ACCESS, BEAT2, DONE, WAITLOW.
- IDLE: when MFA=1, latch RW, DataSize, Address, DataIn and DataInHi.
  - Misaligned request: go to DONE with Misaligned=1. Misaligned means HALF with A[0]!=0, WORD with A[1:0]!=0, or DWORD with A[2:0]!=0.
  - Otherwise: go to ACCESS with the counter set to WAIT_CYCLES-1.
- ACCESS: the counter decrements each cycle. When it reaches 0, the beat is performed.
  - Write: update only the addressed bytes.
  - Read: capture into DataOut, zero-extended. BYTE lands in [7:0], HALF in [15:0]. Sign extension is not done in this block.
  - If DWORD, go to BEAT2 with the counter reloaded; otherwise go to DONE.
- BEAT2: same counting; at 0, perform the second word at A+4 (DataInHi, or capture into DataOutHi), then go to DONE.
- DONE: MOC=1 for exactly one cycle. If MFA is still 1, go to WAITLOW; otherwise go to IDLE.
- WAITLOW: stay until MFA=0, then go to IDLE. A held MFA never retriggers an access.
- Latency, with the request sampled in cycle t:
  - BYTE/HALF/WORD: MOC high in cycle t+WAIT_CYCLES+1.
  - DWORD: MOC high in cycle t+2*WAIT_CYCLES+1.
  - Misaligned: MOC high in cycle t+1.
- Inputs are latched in IDLE only. Changes to inputs while Busy have no effect.
- DataOut and DataOutHi hold their value until the next read beat. Writes do not change them.
- Misaligned is cleared on the next request acceptance.
- Reset mid-operation: return to IDLE next edge with outputs at reset values. A write beat coinciding with reset is not performed.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined: adds output AccessCount [31:0], reset to 0.
  - Increments by 1 on each MOC with Misaligned=0.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - size encodings BYTE=2'b00, HALF=2'b01, WORD=2'b10, DWORD=2'b11;
  - the FSM state encoding;
  - the misalignment-check function.
- Sub-module dmem_lane_unit (combinational) generates:
  - per-byte write enables from size and A[1:0];
  - big-endian write-data placement;
  - read-data extraction and zero-extension.
- The FSM, counter and RAM array stay in data_mem_ctrl.

Test Plan:
- Word round trip, WAIT_CYCLES=2: write WORD 0xDEADBEEF @0x10, then read WORD @0x10 -> DataOut=0xDEADBEEF, MOC 3 cycles after each request.
- Byte write merge: from the state left by the previous test, write BYTE 0x5A @0x12 (DataIn[7:0]=0x5A), then read WORD @0x10 -> 0xDEAD5AEF; read BYTE @0x12 -> 0x0000005A.
- DWORD: write DataIn=0x11223344, DataInHi=0x55667788 @0x20; read DWORD @0x20 -> DataOut=0x11223344, DataOutHi=0x55667788, MOC 5 cycles after the request; WORD read @0x24 -> 0x55667788.
- Misalignment: HALF write @0x31 -> MOC at t+1 with Misaligned=1 and RAM unchanged; DWORD @0x24 -> Misaligned=1.
- Handshake and wrap: MFA held high 10 cycles -> exactly one MOC pulse; WORD write @0x100 with DEPTH=256 -> aliases to @0x00.
- Reset mid-access: assert reset in ACCESS of a WORD write @0x40 -> next cycle Busy=0 and MOC=0, @0x40 keeps its prior value, with DMEM_STATS_EN AccessCount=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: transfer size
// encodings, FSM state encoding and the alignment check used on request entry.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ACCESS  = 3'd1;
    localparam logic [2:0] ST_BEAT2   = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_WAITLOW = 3'd4;

    // A transfer is misaligned when the address is not a multiple of its size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE:  mis = 1'b0;
            SZ_HALF:  mis = addr_lo[0];
            SZ_WORD:  mis = |addr_lo[1:0];
            SZ_DWORD: mis = |addr_lo;
            default:  mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering for one 32-bit word beat (big-endian: the byte at offset 0
// occupies bits [31:24]). Produces write enables, placed write data and the
// zero-extended read value. Purely combinational.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shift;

    // Bring the addressed byte down to [7:0]; offset k sits (3-k) lanes up.
    assign w_shift = i_rword >> {~i_addr_lo, 3'b000};

    // Select enables, write placement and read extraction by transfer size.
    always_comb begin
        o_be    = 4'b0000;
        o_wword = 32'd0;
        o_rdata = 32'd0;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b1000 >> i_addr_lo;
                o_wword = {4{i_wdata[7:0]}};
                o_rdata = {24'd0, w_shift[7:0]};
            end
            SZ_HALF: begin
                if (i_addr_lo[1]) begin
                    o_be    = 4'b0011;
                    o_rdata = {16'd0, i_rword[15:0]};
                end else begin
                    o_be    = 4'b1100;
                    o_rdata = {16'd0, i_rword[31:16]};
                end
                o_wword = {2{i_wdata[15:0]}};
            end
            SZ_WORD, SZ_DWORD: begin
                o_be    = 4'b1111;
                o_wword = i_wdata;
                o_rdata = i_rword;
            end
            default: begin
                o_be    = 4'b0000;
                o_wword = 32'd0;
                o_rdata = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: byte-addressed RAM with BYTE/HALF/WORD/DWORD
// transfers, programmable wait states and an MFA/MOC completion handshake.
// Optional macro DMEM_STATS_EN adds the AccessCount completed-transfer counter.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MFA,
    input  logic        RW,
    input  logic [1:0]  DataSize,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic [31:0] DataInHi,
    output logic [31:0] DataOut,
    output logic [31:0] DataOutHi,
    output logic        MOC,
    output logic        Busy,
    output logic        Misaligned
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] AccessCount
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(WAIT_CYCLES - 1);
    localparam logic [AW-1:0] HI_OFFSET  = AW'(32'd4);

    logic [7:0]    r_mem [0:DEPTH-1];
    logic [2:0]    r_state;
    logic          r_rw;
    logic [1:0]    r_size;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wlo;
    logic [31:0]   r_whi;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_dout;
    logic [31:0]   r_douthi;
    logic          r_moc;
    logic          r_busy;
    logic          r_mis;

    logic [2:0]    w_next_state;
    logic          w_req_mis;
    logic          w_beat;
    logic          w_wr_en;
    logic [AW-1:0] w_beat_addr;
    logic [AW-1:0] w_base;
    logic [31:0]   w_rword;
    logic [3:0]    w_be;
    logic [31:0]   w_wword;
    logic [31:0]   w_rdata;
    logic          w_unused_addr;

    assign w_unused_addr = ^Address[31:AW];
    assign w_req_mis     = is_misaligned(DataSize, Address[2:0]);
    assign w_beat        = ((r_state == ST_ACCESS) || (r_state == ST_BEAT2)) && (r_cnt == '0);
    assign w_wr_en       = !reset && w_beat && !r_rw;
    assign w_beat_addr   = (r_state == ST_BEAT2) ? (r_addr + HI_OFFSET) : r_addr;
    assign w_base        = {w_beat_addr[AW-1:2], 2'b00};

    dmem_lane_unit u_lane (
        .i_size    (r_size),
        .i_addr_lo (w_beat_addr[1:0]),
        .i_wdata   ((r_state == ST_BEAT2) ? r_whi : r_wlo),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wword   (w_wword),
        .o_rdata   (w_rdata)
    );

    // Assemble the big-endian word holding the current beat address.
    always_comb begin
        w_rword = 32'd0;
        for (int j = 0; j < 4; j++) begin
            w_rword[8*j +: 8] = r_mem[w_base | AW'(3 - j)];
        end
    end

    // RAM write port; contents survive reset, a beat under reset is dropped.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int j = 0; j < 4; j++) begin
                if (w_be[j]) begin
                    r_mem[w_base | AW'(3 - j)] <= w_wword[8*j +: 8];
                end
            end
        end
    end

    // Next-state decision for the access sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (MFA) begin
                    w_next_state = w_req_mis ? ST_DONE : ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_next_state = (r_size == SZ_DWORD) ? ST_BEAT2 : ST_DONE;
                end else begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_BEAT2: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_BEAT2;
                end
            end
            ST_DONE:    w_next_state = MFA ? ST_WAITLOW : ST_IDLE;
            ST_WAITLOW: w_next_state = MFA ? ST_WAITLOW : ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Sequencer state, request latch, wait counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rw     <= 1'b0;
            r_size   <= SZ_BYTE;
            r_addr   <= '0;
            r_wlo    <= 32'd0;
            r_whi    <= 32'd0;
            r_cnt    <= '0;
            r_dout   <= 32'd0;
            r_douthi <= 32'd0;
            r_moc    <= 1'b0;
            r_busy   <= 1'b0;
            r_mis    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_moc   <= (w_next_state == ST_DONE);
            r_busy  <= (w_next_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (MFA) begin
                        r_rw   <= RW;
                        r_size <= DataSize;
                        r_addr <= Address[AW-1:0];
                        r_wlo  <= DataIn;
                        r_whi  <= DataInHi;
                        r_mis  <= w_req_mis;
                        r_cnt  <= CNT_RELOAD;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        if (r_rw) begin
                            r_dout <= w_rdata;
                        end
                        r_cnt <= CNT_RELOAD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1'b1);
                    end
                end
                ST_BEAT2: begin
                    if (r_cnt == '0) begin
                        if (r_rw) begin
                            r_douthi <= w_rword;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1'b1);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign DataOut    = r_dout;
    assign DataOutHi  = r_douthi;
    assign MOC        = r_moc;
    assign Busy       = r_busy;
    assign Misaligned = r_mis;

`ifdef DMEM_STATS_EN
    logic [31:0] r_acc_cnt;

    // Count transfers that completed without an alignment rejection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_cnt <= 32'd0;
        end else if (r_moc && !r_mis) begin
            r_acc_cnt <= r_acc_cnt + 32'd1;
        end
    end

    assign AccessCount = r_acc_cnt;
`endif

endmodule
